// File: rtl/motor_speed_ramp_ctrl.sv
// Speed ramp controller: picks a target PWM width from obstacle distance,
// traffic-signal data and stop-line status, then slews pwm_width toward it.
module motor_speed_ramp_ctrl #(
  parameter int PWM_W        = 10,
  parameter int DIST_W       = 8,
  parameter int STOP_DIST    = 5,
  parameter int SLOW_DIST    = 9,
  parameter int SPEED_FAST   = 1000,
  parameter int SPEED_SLOW   = 300,
  parameter int SPEED_CRUISE = 500,
  parameter int SPEED_RESUME = 310,
  parameter int RESET_WIDTH  = 510,
  parameter int RAMP_DIV     = 1000,
  parameter int RAMP_STEP    = 10,
  parameter int LINK_TIMEOUT = 50000,
  parameter int CLEAR_CYCLES = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic [DIST_W-1:0] distance,
  input  logic              sig_valid,
  input  logic [1:0]        sig_color,
  input  logic              cmp_lt,
  input  logic              cmp_gt,
  input  logic              cmp_eq,
  input  logic              signal_reached,
  input  logic              signal_switch,
  output logic [PWM_W-1:0]  pwm_width,
  output logic [PWM_W-1:0]  target_width,
  output logic [2:0]        state,
  output logic              at_target,
  output logic              estop
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CRUISE = 3'd1;
  localparam logic [2:0] ST_ADJUST = 3'd2;
  localparam logic [2:0] ST_HOLD   = 3'd3;
  localparam logic [2:0] ST_ESTOP  = 3'd4;

  localparam logic [1:0] COL_RED = 2'b00;
  localparam logic [1:0] COL_YEL = 2'b01;
  localparam logic [1:0] COL_GRN = 2'b10;
  localparam logic [1:0] COL_INV = 2'b11;

  localparam int PRE_W   = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int AGE_W   = $clog2(LINK_TIMEOUT + 1);
  localparam int CLR_W   = $clog2(CLEAR_CYCLES + 1);
  localparam int PWM_MAX = (1 << PWM_W) - 1;

  localparam logic [DIST_W-1:0] STOP_D   = DIST_W'(STOP_DIST);
  localparam logic [DIST_W-1:0] SLOW_D   = DIST_W'(SLOW_DIST);
  localparam logic [PWM_W-1:0]  W_ZERO   = '0;
  localparam logic [PWM_W-1:0]  W_FAST   = PWM_W'(SPEED_FAST);
  localparam logic [PWM_W-1:0]  W_SLOW   = PWM_W'(SPEED_SLOW);
  localparam logic [PWM_W-1:0]  W_CRUISE = PWM_W'(SPEED_CRUISE);
  localparam logic [PWM_W-1:0]  W_RESUME = PWM_W'(SPEED_RESUME);
  localparam logic [PWM_W-1:0]  W_RESET  = PWM_W'(RESET_WIDTH);
  localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(RAMP_DIV - 1);
  localparam logic [AGE_W-1:0]  AGE_MAX  = AGE_W'(LINK_TIMEOUT);
  localparam logic [CLR_W-1:0]  CLR_LAST = CLR_W'(CLEAR_CYCLES - 1);
  localparam logic signed [PWM_W:0] STEP_S =
    (RAMP_STEP > PWM_MAX) ? (PWM_W+1)'(PWM_MAX) : (PWM_W+1)'(RAMP_STEP);

  // Move cur toward tgt by at most STEP_S; the clamp to |diff| prevents overshoot.
  function automatic logic [PWM_W-1:0] ramp_toward(input logic [PWM_W-1:0] cur,
                                                   input logic [PWM_W-1:0] tgt);
    logic signed [PWM_W:0] diff;
    logic signed [PWM_W:0] mag;
    logic [PWM_W-1:0]      delta;
    diff  = $signed({1'b0, tgt}) - $signed({1'b0, cur});
    mag   = diff[PWM_W] ? -diff : diff;
    delta = (mag > STEP_S) ? STEP_S[PWM_W-1:0] : mag[PWM_W-1:0];
    if (diff[PWM_W])
      ramp_toward = cur - delta;
    else
      ramp_toward = cur + delta;
  endfunction

  logic [1:0]       color_q;
  logic             lt_q;
  logic             gt_q;
  logic             eq_q;
  logic             link_ok;
  logic [AGE_W-1:0] link_age;
  logic [PRE_W-1:0] pre_cnt;
  logic             ramp_tick;
  logic [CLR_W-1:0] clr_cnt;
  logic [CLR_W-1:0] nxt_clr;
  logic [PWM_W-1:0] nxt_target;
  logic [2:0]       nxt_state;
  logic             too_close;

  assign too_close = (distance < STOP_D);
  assign ramp_tick = (pre_cnt == PRE_LAST);
  assign at_target = (pwm_width == target_width);
  assign estop     = (state == ST_ESTOP);

  // Signal latch: invalid colour strobes neither capture nor refresh the link.
  always_ff @(posedge clock) begin
    if (reset) begin
      color_q  <= COL_RED;
      lt_q     <= 1'b0;
      gt_q     <= 1'b0;
      eq_q     <= 1'b0;
      link_ok  <= 1'b0;
      link_age <= '0;
    end else if (sig_valid && (sig_color != COL_INV)) begin
      color_q  <= sig_color;
      lt_q     <= cmp_lt;
      gt_q     <= cmp_gt;
      eq_q     <= cmp_eq;
      link_ok  <= 1'b1;
      link_age <= '0;
    end else if (link_age != AGE_MAX) begin
      link_age <= link_age + 1'b1;
      if (link_age == (AGE_MAX - 1'b1))
        link_ok <= 1'b0;
    end
  end

  // Free-running ramp prescaler
  always_ff @(posedge clock) begin
    if (reset)
      pre_cnt <= '0;
    else if (ramp_tick)
      pre_cnt <= '0;
    else
      pre_cnt <= pre_cnt + 1'b1;
  end

  // Target selection; unassigned branches hold the current target.
  always_comb begin
    nxt_target = target_width;
    if (too_close) begin
      nxt_target = W_ZERO;
    end else if (distance <= SLOW_D) begin
      nxt_target = W_SLOW;
    end else if (!enable) begin
      nxt_target = W_ZERO;
    end else if (signal_reached) begin
      case (color_q)
        COL_RED: nxt_target = signal_switch ? W_RESUME : W_ZERO;
        COL_YEL: if (signal_switch) nxt_target = W_ZERO;
        default: ;
      endcase
    end else if (link_ok) begin
      case (color_q)
        COL_RED: if (!lt_q && (gt_q || eq_q)) nxt_target = W_SLOW;
        COL_YEL: if (lt_q || (!gt_q && eq_q)) nxt_target = W_SLOW;
        COL_GRN: if (lt_q || (!gt_q && eq_q)) nxt_target = W_FAST;
        default: ;
      endcase
    end else begin
      nxt_target = W_CRUISE;
    end
  end

  always_comb begin
    nxt_state = state;
    nxt_clr   = '0;
    if (too_close) begin
      nxt_state = ST_ESTOP;
    end else if (state == ST_ESTOP) begin
      if (clr_cnt == CLR_LAST)
        nxt_state = ST_CRUISE;
      else
        nxt_clr = clr_cnt + 1'b1;
    end else if (!enable) begin
      nxt_state = ST_IDLE;
    end else if (state == ST_IDLE) begin
      nxt_state = ST_CRUISE;
    end else if (signal_reached && (nxt_target == W_ZERO)) begin
      nxt_state = ST_HOLD;
    end else if (state == ST_HOLD) begin
      nxt_state = ST_ADJUST;
    end else begin
      nxt_state = at_target ? ST_CRUISE : ST_ADJUST;
    end
  end

  // Output stage: emergency stop bypasses the ramp on the same edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= ST_CRUISE;
      clr_cnt      <= '0;
      target_width <= W_RESET;
      pwm_width    <= W_RESET;
    end else begin
      state        <= nxt_state;
      clr_cnt      <= nxt_clr;
      target_width <= nxt_target;
      if (too_close || (state == ST_ESTOP))
        pwm_width <= W_ZERO;
      else if (ramp_tick)
        pwm_width <= ramp_toward(pwm_width, target_width);
    end
  end

endmodule

// File: tb/tb_motor_speed_ramp_ctrl.sv
// Scoreboard bench for motor_speed_ramp_ctrl with a fast ramp/link/clear setup.
module tb_motor_speed_ramp_ctrl;

  localparam int SEL_PWM = 0;
  localparam int SEL_TGT = 1;
  localparam int SEL_ST  = 2;
  localparam int SEL_ES  = 3;
  localparam int SEL_AT  = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       enable;
  logic [7:0] distance;
  logic       sig_valid;
  logic [1:0] sig_color;
  logic       cmp_lt;
  logic       cmp_gt;
  logic       cmp_eq;
  logic       signal_reached;
  logic       signal_switch;
  logic [9:0] pwm_width;
  logic [9:0] target_width;
  logic [2:0] state;
  logic       at_target;
  logic       estop;

  typedef struct {
    string name;
    int    sel;
    int    exp;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   mon_act;
  int   n_vec = 0;
  int   n_bad = 0;
  int   cur   = 0;

  always #5 clock = ~clock;

  motor_speed_ramp_ctrl #(
    .RAMP_DIV    (4),
    .RAMP_STEP   (100),
    .LINK_TIMEOUT(16),
    .CLEAR_CYCLES(3)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .enable        (enable),
    .distance      (distance),
    .sig_valid     (sig_valid),
    .sig_color     (sig_color),
    .cmp_lt        (cmp_lt),
    .cmp_gt        (cmp_gt),
    .cmp_eq        (cmp_eq),
    .signal_reached(signal_reached),
    .signal_switch (signal_switch),
    .pwm_width     (pwm_width),
    .target_width  (target_width),
    .state         (state),
    .at_target     (at_target),
    .estop         (estop)
  );

  function automatic int actual(input int sel);
    case (sel)
      SEL_PWM: actual = int'(pwm_width);
      SEL_TGT: actual = int'(target_width);
      SEL_ST:  actual = int'(state);
      SEL_ES:  actual = int'(estop);
      default: actual = int'(at_target);
    endcase
  endfunction

  // Monitor: pops every pending expectation once outputs are stable.
  always @(negedge clock) begin
    while (exp_q.size() > 0) begin
      mon_e   = exp_q.pop_front();
      mon_act = actual(mon_e.sel);
      n_vec++;
      if (mon_act != mon_e.exp) begin
        n_bad++;
        $display("FAIL %s: got %0d, expected %0d", mon_e.name, mon_act, mon_e.exp);
      end
    end
  end

  task automatic expect_val(input string name, input int sel, input int exp);
    exp_t e;
    e.name = name;
    e.sel  = sel;
    e.exp  = exp;
    exp_q.push_back(e);
  endtask

  // Advance to 1 time unit after edge k (edges counted from reset release).
  task automatic goto(input int k);
    while (cur < k) begin
      @(posedge clock);
      cur++;
    end
    #1;
  endtask

  task automatic set_sig(input logic v, input logic [1:0] c,
                         input logic lt, input logic gt, input logic eq);
    sig_valid = v;
    sig_color = c;
    cmp_lt    = lt;
    cmp_gt    = gt;
    cmp_eq    = eq;
  endtask

  initial begin
    enable         = 1'b1;
    distance       = 8'd50;
    signal_reached = 1'b0;
    signal_switch  = 1'b0;
    set_sig(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clock);
    #1;
    expect_val("rst_pwm", SEL_PWM, 510);
    expect_val("rst_tgt", SEL_TGT, 510);
    expect_val("rst_state", SEL_ST, 1);
    expect_val("rst_estop", SEL_ES, 0);
    expect_val("rst_at_target", SEL_AT, 1);
    reset = 1'b0;

    goto(1);  expect_val("cruise_tgt", SEL_TGT, 500);
    goto(4);  expect_val("first_tick_pwm", SEL_PWM, 500);
    goto(5);  expect_val("cruise_state", SEL_ST, 1);
              expect_val("cruise_at_target", SEL_AT, 1);
              set_sig(1'b1, 2'b10, 1'b1, 1'b0, 1'b0);
    goto(6);  expect_val("capture_latency_tgt", SEL_TGT, 500);
    goto(7);  expect_val("green_lt_tgt", SEL_TGT, 1000);
    goto(8);  expect_val("ramp_pwm_600", SEL_PWM, 600);
              expect_val("ramp_state_adjust", SEL_ST, 2);
    goto(11); expect_val("ramp_between_ticks", SEL_PWM, 600);
    goto(12); expect_val("ramp_pwm_700", SEL_PWM, 700);
    goto(24); expect_val("ramp_pwm_1000", SEL_PWM, 1000);
              expect_val("ramp_last_adjust", SEL_ST, 2);
    goto(25); expect_val("ramp_done_state", SEL_ST, 1);
              expect_val("ramp_done_at_target", SEL_AT, 1);
              distance = 8'd3;
    goto(26); expect_val("estop_pwm", SEL_PWM, 0);
              expect_val("estop_flag", SEL_ES, 1);
              expect_val("estop_state", SEL_ST, 4);
              distance = 8'd20;
    goto(28); expect_val("estop_clear2", SEL_ST, 4);
              distance = 8'd4;
    goto(29); expect_val("estop_violation", SEL_ST, 4);
              expect_val("estop_violation_pwm", SEL_PWM, 0);
              distance = 8'd20;
    goto(31); expect_val("estop_still", SEL_ES, 1);
    goto(32); expect_val("estop_exit_state", SEL_ST, 1);
              expect_val("estop_exit_flag", SEL_ES, 0);
              expect_val("estop_exit_pwm", SEL_PWM, 0);
    goto(33); expect_val("post_estop_adjust", SEL_ST, 2);
    goto(36); expect_val("post_estop_pwm", SEL_PWM, 100);
              set_sig(1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
              signal_reached = 1'b1;
    goto(37); expect_val("reached_green_hold", SEL_TGT, 1000);
    goto(38); expect_val("red_stop_tgt", SEL_TGT, 0);
              expect_val("hold_sig_state", SEL_ST, 3);
    goto(40); expect_val("red_stop_pwm", SEL_PWM, 0);
    goto(41); expect_val("hold_sig_stay", SEL_ST, 3);
              expect_val("hold_sig_at_target", SEL_AT, 1);
              signal_switch = 1'b1;
    goto(42); expect_val("resume_tgt", SEL_TGT, 310);
              expect_val("resume_state", SEL_ST, 2);
    goto(44); expect_val("resume_pwm_100", SEL_PWM, 100);
    goto(56); expect_val("resume_pwm_310", SEL_PWM, 310);
    goto(57); expect_val("resume_cruise", SEL_ST, 1);
              signal_reached = 1'b0;
              signal_switch  = 1'b0;
              set_sig(1'b1, 2'b10, 1'b1, 1'b0, 1'b0);
    goto(58); set_sig(1'b0, 2'b10, 1'b1, 1'b0, 1'b0);
    goto(59); expect_val("link_fast_tgt", SEL_TGT, 1000);
    goto(72); expect_val("link_pwm_710", SEL_PWM, 710);
    goto(74); expect_val("link_last_ok_tgt", SEL_TGT, 1000);
    goto(75); expect_val("link_lost_tgt", SEL_TGT, 500);
              set_sig(1'b1, 2'b11, 1'b1, 1'b0, 1'b0);
    goto(76); set_sig(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
              expect_val("ramp_down_pwm", SEL_PWM, 610);
    goto(77); expect_val("invalid_colour_ignored", SEL_TGT, 500);
              set_sig(1'b1, 2'b10, 1'b1, 1'b0, 1'b0);
              distance = 8'd7;
    goto(78); expect_val("slow_band_tgt", SEL_TGT, 300);
    goto(79); enable   = 1'b0;
              distance = 8'd50;
    goto(80); expect_val("disable_tgt", SEL_TGT, 0);
              expect_val("disable_state", SEL_ST, 0);
              expect_val("disable_pwm_510", SEL_PWM, 510);
    goto(84); expect_val("disable_pwm_410", SEL_PWM, 410);
              expect_val("idle_stay", SEL_ST, 0);
              enable = 1'b1;
    goto(85); expect_val("idle_to_cruise", SEL_ST, 1);
              reset = 1'b1;
    goto(86); expect_val("midramp_rst_pwm", SEL_PWM, 510);
              expect_val("midramp_rst_tgt", SEL_TGT, 510);
              expect_val("midramp_rst_state", SEL_ST, 1);
              expect_val("midramp_rst_estop", SEL_ES, 0);
              expect_val("midramp_rst_at_target", SEL_AT, 1);
              reset = 1'b0;

    @(negedge clock);
    #1;
    if (exp_q.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
